dac_pair_scheduler: RTL
=======================

# dac_pair_scheduler

Sample-rate scheduler that sits in front of the dual-channel AD56x3 DAC interface core. It buffers channel A and channel B samples from two independent Avalon-ST sources in small FIFOs. On each tick of a programmable sample-rate timer, it pops one A/B pair and presents it to the core's sink as a single transfer. Underruns (a missing sample) and late ticks (core still busy) are flagged, and the DAC holds its last pair.

## Interface
Parameters:
- DATA_WIDTH, 14, sample width; must match the DAC core
- FIFO_DEPTH, 8, entries per channel FIFO; power of 2, ≥ 2
- PERIOD_WIDTH, 16, width of cfgPeriod
- CNT_WIDTH, 16, width of underrun counter

Ports:
- clk  in  1  single clock domain
- reset  in  1  synchronous, active-low reset
- cfgEnable  in  1  run sample timer
- cfgPeriod  in  PERIOD_WIDTH  tick every cfgPeriod+1 clk cycles
- inValidA / inDataA / inRdyA  in / in / out  1 / DATA_WIDTH / 1  channel A Avalon-ST sink
- inValidB / inDataB / inRdyB  in / in / out  1 / DATA_WIDTH / 1  channel B Avalon-ST sink
- outValid  out  1  pair valid; drives core valid0 and valid1
- outData0 / outData1  out  DATA_WIDTH  channel A / channel B sample to core
- outRdy  in  1  core ready
- statUnderrun  out  1  one-cycle pulse per underrun tick
- statLate  out  1  one-cycle pulse per tick dropped while busy
- statUnderrunCnt  out  CNT_WIDTH  saturating underrun count (macro-gated)

## Operation
- FIFOs:
  - Push on inValidX & inRdyX; inRdyX = ~fullX.
  - Push and pop in the same cycle are legal when the FIFO is non-empty.
  - A word pushed in cycle T is poppable from T+1.
- Timer:
  - tickCnt increments each cycle while cfgEnable = 1.
  - tick = cfgEnable & (tickCnt >= cfgPeriod), combinational from registers. On tick, tickCnt ← 0.
  - cfgEnable = 0 forces tickCnt ← 0. A runtime cfgPeriod decrease below tickCnt produces a tick on the next cycle (no wrap).
- FSM states: IDLE, WAIT, ISSUE.
  - IDLE: outValid = 0. Go to WAIT when cfgEnable = 1.
  - WAIT, on tick:
    - Both FIFOs non-empty: pop one word from each, load outData0/outData1, go to ISSUE.
    - Either FIFO empty: pop neither (keeps A/B alignment), pulse statUnderrun, keep previous outData0/outData1, go to ISSUE (repeat the last pair).
  - WAIT with cfgEnable = 0: go to IDLE.
  - ISSUE: outValid = 1, outData stable. On outRdy = 1 the transfer completes and the FSM goes to WAIT, or to IDLE if cfgEnable = 0. Disabling never withdraws a presented transfer.
  - A tick in ISSUE is dropped: pulse statLate, nothing popped.
- FIFOs keep accepting data while disabled; contents are preserved across disable/enable.
- Reset (any cycle, including mid-ISSUE):
  - FIFOs emptied, tickCnt = 0, state IDLE.
  - outValid = 0, outData0 = outData1 = 0.
  - statUnderrun = statLate = 0, statUnderrunCnt = 0.
  - inRdyA = inRdyB = 1 in the first cycle after reset release.

## Timing
- Tick in cycle T → pop in T → outValid = 1 and new data in T+1.
- First tick occurs cfgPeriod+1 cycles after cfgEnable rises; ticks then repeat every cfgPeriod+1 cycles.
- Transfer completes in the first cycle in ISSUE with outRdy = 1; WAIT is re-entered the next cycle. Minimum tick spacing without statLate is 2 cycles plus the core's ready latency.
- statUnderrun and statLate are registered, asserted in T+1 for a tick in T.
- Tick in the same cycle as a push into an empty FIFO → underrun.

## Configuration
- DAC_SCHED_UNDERRUN_CNT_EN:
  - Defined: statUnderrunCnt increments on each statUnderrun pulse and saturates at all-ones; cleared only by reset.
  - Undefined: counter logic removed and statUnderrunCnt tied to 0. The port remains.

## Structure
- Package dac_sched_pkg holds:
  - the FSM state enum (IDLE, WAIT, ISSUE)
  - the FIFO_DEPTH power-of-2 check function
  - the reset-value constant for outData
- One sub-module, dac_sched_fifo: synchronous FIFO with full/empty flags, instantiated twice.
- Timer, FSM and stats live in the top module.

## Test plan
- cfgPeriod = 9, both FIFOs preloaded with A = 1..4 and B = 101..104, outRdy tied 1 → outValid pulses every 10 cycles with pairs (1,101)..(4,104); first pulse 11 cycles after enable.
- Only A is fed (A = 5), B is empty, at tick → statUnderrun pulse, outData = (0,0) repeated, A FIFO count unchanged; next pair output after B is fed is (5, firstB).
- outRdy held low for 25 cycles with cfgPeriod = 9 → two statLate pulses, outValid stays high with stable data, no pops.
- Push 8 words into A with no ticks → inRdyA = 0 after the 8th push; a 9th valid word is not accepted; one pop restores inRdyA the next cycle.
- cfgEnable dropped while in ISSUE with outRdy = 0 → outValid held until outRdy, then IDLE; reset asserted mid-ISSUE → all outputs return to reset values the next cycle.
- With DAC_SCHED_UNDERRUN_CNT_EN and CNT_WIDTH = 2, five underruns → statUnderrunCnt = 3; with the macro undefined → 0.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC pair scheduler: FSM state encoding,
// the FIFO depth sanity check, and the output data reset value.
package dac_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } sched_state_t;

    localparam int unsigned OUT_DATA_RESET = 0;

    function automatic bit is_pow2(input int value);
        return (value >= 2) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/dac_sched_fifo.sv
// Small synchronous FIFO with full/empty flags. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
// Pushes while full and pops while empty are ignored.
module dac_sched_fifo
    import dac_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("dac_sched_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

    // Advance read/write pointers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        end
    end

    // Storage array; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_data;
    end

endmodule

// File: rtl/dac_pair_scheduler.sv
// Sample-rate scheduler in front of a dual-channel DAC core. Buffers A and B
// samples, and on each timer tick presents one A/B pair to the core. Missing
// samples (underrun) repeat the last pair; ticks while busy are dropped (late).
// Optional feature macro: DAC_SCHED_UNDERRUN_CNT_EN enables the saturating
// underrun counter; without it statUnderrunCnt is tied to zero.
module dac_pair_scheduler
    import dac_sched_pkg::*;
#(
    parameter int DATA_WIDTH   = 14,
    parameter int FIFO_DEPTH   = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfgEnable,
    input  logic [PERIOD_WIDTH-1:0] cfgPeriod,
    input  logic                    inValidA,
    input  logic [DATA_WIDTH-1:0]   inDataA,
    output logic                    inRdyA,
    input  logic                    inValidB,
    input  logic [DATA_WIDTH-1:0]   inDataB,
    output logic                    inRdyB,
    output logic                    outValid,
    output logic [DATA_WIDTH-1:0]   outData0,
    output logic [DATA_WIDTH-1:0]   outData1,
    input  logic                    outRdy,
    output logic                    statUnderrun,
    output logic                    statLate,
    output logic [CNT_WIDTH-1:0]    statUnderrunCnt
);

    sched_state_t            state;
    sched_state_t            state_next;
    logic [PERIOD_WIDTH-1:0] tick_cnt;
    logic                    tick;
    logic                    pop_pair;
    logic                    underrun_next;
    logic                    late_next;
    logic                    full_a;
    logic                    full_b;
    logic                    empty_a;
    logic                    empty_b;
    logic [DATA_WIDTH-1:0]   head_a;
    logic [DATA_WIDTH-1:0]   head_b;

    dac_sched_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .reset     (reset),
        .push      (inValidA),
        .push_data (inDataA),
        .pop       (pop_pair),
        .pop_data  (head_a),
        .full      (full_a),
        .empty     (empty_a)
    );

    dac_sched_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .reset     (reset),
        .push      (inValidB),
        .push_data (inDataB),
        .pop       (pop_pair),
        .pop_data  (head_b),
        .full      (full_b),
        .empty     (empty_b)
    );

    assign inRdyA   = ~full_a;
    assign inRdyB   = ~full_b;
    assign tick     = cfgEnable && (tick_cnt >= cfgPeriod);
    assign outValid = (state == ISSUE);

    // Sample-rate timer: counts while enabled, restarts on every tick or disable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (!cfgEnable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + PERIOD_WIDTH'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; pops both FIFOs together so A/B never drift apart.
    always_comb begin
        state_next    = state;
        pop_pair      = 1'b0;
        underrun_next = 1'b0;
        late_next     = 1'b0;
        case (state)
            IDLE: begin
                if (cfgEnable) state_next = WAIT;
            end
            WAIT: begin
                if (tick) begin
                    state_next = ISSUE;
                    if (!empty_a && !empty_b) begin
                        pop_pair = 1'b1;
                    end else begin
                        underrun_next = 1'b1;
                    end
                end else if (!cfgEnable) begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                if (tick) late_next = 1'b1;
                if (outRdy) state_next = cfgEnable ? WAIT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output pair register; only a successful pop replaces it, so an underrun repeats it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            outData0 <= DATA_WIDTH'(OUT_DATA_RESET);
            outData1 <= DATA_WIDTH'(OUT_DATA_RESET);
        end else if (pop_pair) begin
            outData0 <= head_a;
            outData1 <= head_b;
        end
    end

    // Registered status pulses, visible the cycle after the tick that caused them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            statUnderrun <= 1'b0;
            statLate     <= 1'b0;
        end else begin
            statUnderrun <= underrun_next;
            statLate     <= late_next;
        end
    end

`ifdef DAC_SCHED_UNDERRUN_CNT_EN
    logic [CNT_WIDTH-1:0] underrun_cnt;

    // Saturating underrun counter, stepped alongside each underrun pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            underrun_cnt <= '0;
        end else if (underrun_next && (underrun_cnt != {CNT_WIDTH{1'b1}})) begin
            underrun_cnt <= underrun_cnt + CNT_WIDTH'(1);
        end
    end

    assign statUnderrunCnt = underrun_cnt;
`else
    assign statUnderrunCnt = '0;
`endif

endmodule
